lc3_mem_arbiter: RTL

- Shares one unified memory port between two requesters: the fetch stage (instruction read) and the memaccess stage (data read/write).
- Sits between the LC3 core and the memory that the inst_mem and data_mem agents model today, so a single-port memory can back both.
- Fixed data-over-instruction priority, with a starvation guard for fetch.
- One outstanding transaction at a time; fixed memory read latency.

---
 rtl/lc3_mem_arb_pkg.sv | 16 +
 rtl/lc3_mem_arb_pick.sv | 18 +
 rtl/lc3_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lc3_mem_arb_pkg.sv
// Shared types and defaults for the LC3 unified-memory arbiter.
package lc3_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  localparam int DEF_MEM_LATENCY  = 1;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int LAT_W            = 3;
  localparam int STARVE_W         = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lc3_mem_arb_pick.sv
// Combinational winner select: data beats inst unless inst has been starved.
module lc3_mem_arb_pick
  import lc3_mem_arb_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   starved,
  output logic   grant,
  output owner_t owner
);

  always_comb begin
    grant = inst_req | data_req;
    owner = OWN_DATA;
    if (inst_req && (!data_req || starved)) owner = OWN_INST;
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter (fetch / memaccess) onto one fixed-latency memory port.
// Optional statistics counters are built when LC3_MEM_ARB_STATS_EN is defined.
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ack,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef LC3_MEM_ARB_STATS_EN
 ,output logic [15:0]       inst_grant_cnt,
  output logic [15:0]       data_grant_cnt,
  output logic [15:0]       starve_evt_cnt
`endif
);

  localparam logic [LAT_W-1:0]    LAT_LOAD = LAT_W'(MEM_LATENCY);
  localparam logic [STARVE_W-1:0] LIMIT    = STARVE_W'(STARVE_LIMIT);

  arb_state_t            state;
  owner_t                owner, win;
  logic                  grant, starved, owner_we;
  logic [LAT_W-1:0]      lat_cnt;
  logic [STARVE_W-1:0]   starve_cnt;

  assign starved = (starve_cnt == LIMIT);

  lc3_mem_arb_pick u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
    .starved  (starved),
    .grant    (grant),
    .owner    (win)
  );

  // mem_addr/mem_din double as the request latches; they hold until the next grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_INST;
      owner_we   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner  <= win;
            mem_en <= 1'b1;
            state  <= ISSUE;
            if (win == OWN_DATA) begin
              mem_addr <= data_addr;
              mem_we   <= data_we;
              owner_we <= data_we;
              mem_din  <= data_wdata;
            end else begin
              mem_addr <= inst_addr;
              mem_we   <= 1'b0;
              owner_we <= 1'b0;
              mem_din  <= '0;
            end
          end
          // inst_req high implies a grant, so the increment only happens on data wins
          if (!inst_req || win == OWN_INST) starve_cnt <= '0;
          else if (!starved)                starve_cnt <= starve_cnt + STARVE_W'(1);
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            state <= RESP;
            if (owner == OWN_INST) begin
              inst_rdata <= mem_dout;
              inst_ack   <= 1'b1;
            end else begin
              data_ack <= 1'b1;
              if (!owner_we) data_rdata <= mem_dout;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LC3_MEM_ARB_STATS_EN
  logic issue_go;
  assign issue_go = (state == IDLE) && grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inst_grant_cnt <= '0;
      data_grant_cnt <= '0;
      starve_evt_cnt <= '0;
    end else if (issue_go) begin
      if (win == OWN_INST) inst_grant_cnt <= sat_inc16(inst_grant_cnt);
      else                 data_grant_cnt <= sat_inc16(data_grant_cnt);
      if (win == OWN_INST && data_req && starved)
        starve_evt_cnt <= sat_inc16(starve_evt_cnt);
    end
  end
`endif

endmodule
